// File: rtl/fadd_pipe_sched_pkg.sv
// Shared FPU definitions: word widths, rounding-mode encodings and the canonical quiet NaN.
package fadd_pipe_sched_pkg;

    localparam int FP_W = 32;
    localparam int RM_W = 2;

    typedef enum logic [RM_W-1:0] {
        RNE = 2'd0,
        RZ  = 2'd1,
        RUP = 2'd2,
        RDN = 2'd3
    } rm_e;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/float_adder_pipe.sv
// Single-precision IEEE-754 adder: align into a2c, add into c2n, then normalise/round/pack
// combinationally from c2n. Every register advances only while en is high.
module float_adder_pipe
    import fadd_pipe_sched_pkg::*;
(
    input  logic            clk,
    input  logic            en,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            sub,
    input  logic [RM_W-1:0] rm,
    output logic [FP_W-1:0] s
);

    function automatic logic round_up(input logic [RM_W-1:0] mode, input logic sign,
                                      input logic lsb, input logic guard, input logic sticky);
        case (rm_e'(mode))
            RNE:     round_up = guard & (sticky | lsb);
            RZ:      round_up = 1'b0;
            RUP:     round_up = ~sign & (guard | sticky);
            default: round_up = sign & (guard | sticky);
        endcase
    endfunction

    function automatic logic [FP_W-1:0] pack(input logic sign, input logic [9:0] exp,
                                             input logic [23:0] mant, input logic [RM_W-1:0] mode);
        logic to_inf;
        to_inf = 1'b0;
        if (exp >= 10'd255) begin
            case (rm_e'(mode))
                RNE:     to_inf = 1'b1;
                RZ:      to_inf = 1'b0;
                RUP:     to_inf = ~sign;
                default: to_inf = sign;
            endcase
            pack = to_inf ? {sign, 8'hFF, 23'h0} : {sign, 8'hFE, 23'h7F_FFFF};
        end else begin
            // A clear hidden bit at the minimum exponent means the result is subnormal.
            pack = {sign, mant[23] ? exp[7:0] : 8'h00, mant[22:0]};
        end
    endfunction

    logic            b_sign, mag_ge, a_nan, b_nan, a_inf, b_inf;
    logic [FP_W-1:0] x, y;
    logic [7:0]      ex, ey, d;
    logic [4:0]      dcap;
    logic [23:0]     mx, my;
    logic [53:0]     wide;
    logic [26:0]     my_al;

    // Stage a: unpack, order by magnitude, align the smaller operand with sticky
    always_comb begin
        b_sign = b[31] ^ sub;
        mag_ge = a[30:0] >= b[30:0];
        x      = mag_ge ? a : {b_sign, b[30:0]};
        y      = mag_ge ? {b_sign, b[30:0]} : a;
        ex     = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey     = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx     = {x[30:23] != 8'd0, x[22:0]};
        my     = {y[30:23] != 8'd0, y[22:0]};
        d      = ex - ey;
        dcap   = (d > 8'd27) ? 5'd27 : d[4:0];
        wide   = {my, 3'b000, 27'd0} >> dcap;
        my_al  = {wide[53:28], wide[27] | (|wide[26:0])};
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    end

    logic            sx_p1, sy_p1, nan_p1, inf_p1, infs_p1;
    logic [7:0]      ex_p1;
    logic [23:0]     mx_p1;
    logic [26:0]     my_p1;
    logic [RM_W-1:0] rm_p1;

    always_ff @(posedge clk) begin
        if (en) begin
            sx_p1   <= x[31];
            sy_p1   <= y[31];
            ex_p1   <= ex;
            mx_p1   <= mx;
            my_p1   <= my_al;
            nan_p1  <= a_nan | b_nan | (a_inf & b_inf & (a[31] != b_sign));
            inf_p1  <= a_inf | b_inf;
            infs_p1 <= a_inf ? a[31] : b_sign;
            rm_p1   <= rm;
        end
    end

    logic [27:0] sum_c;
    logic        sign_c;

    // Stage c: magnitude add/subtract; an exact zero from opposite signs takes +0 except under RDN
    always_comb begin
        if (sx_p1 == sy_p1) sum_c = {1'b0, mx_p1, 3'b000} + {1'b0, my_p1};
        else                sum_c = {1'b0, mx_p1, 3'b000} - {1'b0, my_p1};
        sign_c = sx_p1;
        if (sum_c == 28'd0 && sx_p1 != sy_p1) sign_c = (rm_e'(rm_p1) == RDN);
    end

    logic            sign_p2, nan_p2, inf_p2, infs_p2;
    logic [7:0]      ex_p2;
    logic [27:0]     sum_p2;
    logic [RM_W-1:0] rm_p2;

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p2 <= sign_c;
            ex_p2   <= ex_p1;
            sum_p2  <= sum_c;
            nan_p2  <= nan_p1;
            inf_p2  <= inf_p1;
            infs_p2 <= infs_p1;
            rm_p2   <= rm_p1;
        end
    end

    logic [4:0]  lead, lsh;
    logic [26:0] norm;
    logic [9:0]  exp_n;
    logic        inc;
    logic [24:0] mant_r;
    logic [23:0] mant;

    // Stage n: normalise (left shift limited so the exponent never drops below 1), round, pack
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum_p2[i]) lead = 5'(i);
        end
        lsh = 5'd26 - lead;
        if ({3'b000, lsh} > (ex_p2 - 8'd1)) lsh = 5'(ex_p2 - 8'd1);
        if (sum_p2[27]) begin
            norm  = {sum_p2[27:2], |sum_p2[1:0]};
            exp_n = {2'b00, ex_p2} + 10'd1;
        end else begin
            norm  = sum_p2[26:0] << lsh;
            exp_n = {2'b00, ex_p2} - {5'd0, lsh};
        end
        inc    = round_up(rm_p2, sign_p2, norm[3], norm[2], |norm[1:0]);
        mant_r = {1'b0, norm[26:3]} + {24'd0, inc};
        mant   = mant_r[23:0];
        if (mant_r[24]) begin
            mant  = mant_r[24:1];
            exp_n = exp_n + 10'd1;
        end
        if (nan_p2)                s = FP_QNAN;
        else if (inf_p2)           s = {infs_p2, 8'hFF, 23'h0};
        else if (sum_p2 == 28'd0)  s = {sign_p2, 31'h0};
        else                       s = pack(sign_p2, exp_n, mant, rm_p2);
    end

endmodule

// File: rtl/fadd_pipe_sched.sv
// Round-robin front end sharing one pipelined FP adder between two requesters, with
// per-stage valid/ID/tag shadows and a single registered valid/ready result port.
module fadd_pipe_sched
    import fadd_pipe_sched_pkg::*;
#(
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [FP_W-1:0] req_a0,
    input  logic [FP_W-1:0] req_b0,
    input  logic [FP_W-1:0] req_a1,
    input  logic [FP_W-1:0] req_b1,
    input  logic [1:0]      req_sub,
    input  logic [RM_W-1:0] req_rm0,
    input  logic [RM_W-1:0] req_rm1,
    input  logic [TAGW-1:0] req_tag0,
    input  logic [TAGW-1:0] req_tag1,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [FP_W-1:0] res_data,
    output logic            res_id,
    output logic [TAGW-1:0] res_tag,
    output logic            busy
);

    logic            en, accept, gid, last;
    logic [1:0]      grant;
    logic            vc, vn, idc, idn;
    logic [TAGW-1:0] tagc, tagn;
    logic [FP_W-1:0] add_a, add_b, add_s;
    logic            add_sub;
    logic [RM_W-1:0] add_rm;

    // The whole pipe freezes only when a finished result in c2n has nowhere to go.
    assign en = !(vn && res_valid && !res_ready);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        req_ready = grant;
        accept    = |grant;
        gid       = grant[1];
        add_a     = gid ? req_a1 : req_a0;
        add_b     = gid ? req_b1 : req_b0;
        add_sub   = gid ? req_sub[1] : req_sub[0];
        add_rm    = gid ? req_rm1 : req_rm0;
    end

    float_adder_pipe u_add (
        .clk (clk),
        .en  (en),
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .rm  (add_rm),
        .s   (add_s)
    );

    // Control state: shadow valids, arbitration history and the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vc        <= 1'b0;
            vn        <= 1'b0;
            last      <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            res_tag   <= '0;
        end else begin
            if (en) begin
                vn <= vc;
                vc <= accept;
            end
            if (accept) last <= gid;
            if (vn && en) begin
                res_valid <= 1'b1;
                res_data  <= add_s;
                res_id    <= idn;
                res_tag   <= tagn;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // ID/tag shadows ride alongside the adder's a2c and c2n registers
    always_ff @(posedge clk) begin
        if (en) begin
            idn  <= idc;
            tagn <= tagc;
            idc  <= gid;
            tagc <= gid ? req_tag1 : req_tag0;
        end
    end

    assign busy = vc | vn | res_valid;

endmodule

// File: tb/tb_fadd_pipe_sched.sv
// Random and directed stimulus against an exact-arithmetic FP reference and an in-flight queue.
`timescale 1ns/1ps
module tb_fadd_pipe_sched;
    import fadd_pipe_sched_pkg::*;

    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [31:0]     req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]      req_sub = '0;
    logic [1:0]      req_rm0 = '0, req_rm1 = '0;
    logic [TAGW-1:0] req_tag0 = '0, req_tag1 = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [31:0]     res_data;
    logic            res_id;
    logic [TAGW-1:0] res_tag;
    logic            busy;

    always #5 clk = ~clk;

    fadd_pipe_sched #(.TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_sub(req_sub), .req_rm0(req_rm0), .req_rm1(req_rm1),
        .req_tag0(req_tag0), .req_tag1(req_tag1), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_tag(res_tag), .busy(busy)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Exact reference: sum both operands as wide integers on a common exponent, then round once.
    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [1:0] rm);
        logic sa, sb, sgn, inc, a_nan, b_nan, a_inf, b_inf;
        int ea, eb, emin, q, lsb, sh, e;
        logic [299:0] ma, mb, mag, kept, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        a_nan = a[30:23] == 8'hFF && a[22:0] != 0;
        b_nan = b[30:23] == 8'hFF && b[22:0] != 0;
        a_inf = a[30:23] == 8'hFF && a[22:0] == 0;
        b_inf = b[30:23] == 8'hFF && b[22:0] == 0;
        if (a_nan || b_nan) return 32'h7FC00000;
        if (a_inf && b_inf) return (sa == sb) ? {sa, 8'hFF, 23'h0} : 32'h7FC00000;
        if (a_inf) return {sa, 8'hFF, 23'h0};
        if (b_inf) return {sb, 8'hFF, 23'h0};
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = '0; ma[23:0] = {a[30:23] != 0, a[22:0]};
        mb = '0; mb[23:0] = {b[30:23] != 0, b[22:0]};
        emin = (ea < eb) ? ea : eb;
        ma = ma << (ea - emin);
        mb = mb << (eb - emin);
        if (sa == sb)      begin mag = ma + mb; sgn = sa; end
        else if (ma >= mb) begin mag = ma - mb; sgn = sa; end
        else               begin mag = mb - ma; sgn = sb; end
        if (mag == 0) return {(sa == sb) ? sa : (rm == 2'd3), 31'h0};
        q = 0;
        for (int i = 299; i >= 0; i--) if (mag[i]) begin q = i; break; end
        // value = mag * 2^(emin-150); keep 24 significant bits, never below 2^-149
        lsb = q - 23 + emin - 150;
        if (lsb < -149) lsb = -149;
        sh = lsb - (emin - 150);
        half = 300'd1;
        if (sh <= 0) begin kept = mag << (-sh); rem = '0; end
        else begin
            kept = mag >> sh;
            rem  = mag - (kept << sh);
            half = half << (sh - 1);
        end
        case (rm)
            2'd0:    inc = (rem > half) || (rem == half && kept[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !sgn && rem != 0;
            default: inc = sgn && rem != 0;
        endcase
        kept = kept + {299'd0, inc};
        if (kept[24]) begin kept = kept >> 1; lsb++; end
        if (!kept[23]) return {sgn, 8'h00, kept[22:0]};
        e = lsb + 150;
        if (e >= 255) begin
            if (rm == 2'd1 || (rm == 2'd2 && sgn) || (rm == 2'd3 && !sgn))
                return {sgn, 8'hFE, 23'h7FFFFF};
            return {sgn, 8'hFF, 23'h0};
        end
        return {sgn, 8'(e), kept[22:0]};
    endfunction

    typedef struct {
        logic [31:0]     data;
        logic            id;
        logic [TAGW-1:0] tag;
        int              age;
    } ent_t;

    ent_t       q[$];
    logic       last_m = 1'b1;
    int         delivered = 0;

    // Scoreboard: an op becomes visible at the third advancing edge counting its acceptance;
    // the pipe freezes while the visible head is refused and a second op is one edge behind it.
    initial begin
        logic vis, stall_m;
        logic [1:0] grant_m;
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                last_m = 1'b1;
                chk("rst_res_valid", res_valid, 0);
                chk("rst_busy", busy, 0);
            end else begin
                vis = q.size() > 0 && q[0].age >= 3;
                chk("res_valid", res_valid, vis);
                if (vis) begin
                    chk("res_data", res_data, q[0].data);
                    chk("res_id", res_id, q[0].id);
                    chk("res_tag", res_tag, q[0].tag);
                end
                chk("busy", busy, q.size() > 0);
                stall_m = vis && !res_ready && q.size() >= 2 && q[1].age == 2;
                grant_m = 2'b00;
                if (!stall_m) begin
                    if (req_valid == 2'b01) grant_m = 2'b01;
                    else if (req_valid == 2'b10) grant_m = 2'b10;
                    else if (req_valid == 2'b11) grant_m = last_m ? 2'b01 : 2'b10;
                end
                chk("req_ready", req_ready, grant_m);
                if (vis && res_ready) begin
                    void'(q.pop_front());
                    delivered++;
                end
                if (!stall_m) begin
                    foreach (q[i]) if (q[i].age < 3) q[i].age = q[i].age + 1;
                end
                if (grant_m != 2'b00) begin
                    e.id   = grant_m[1];
                    e.data = grant_m[1] ? fp_ref(req_a1, req_b1, req_sub[1], req_rm1)
                                        : fp_ref(req_a0, req_b0, req_sub[0], req_rm0);
                    e.tag  = grant_m[1] ? req_tag1 : req_tag0;
                    e.age  = 1;
                    q.push_back(e);
                    last_m = grant_m[1];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [1:0] rm, input logic [TAGW-1:0] tag);
        if (r == 0) begin req_a0 = a; req_b0 = b; req_sub[0] = sub; req_rm0 = rm; req_tag0 = tag; end
        else        begin req_a1 = a; req_b1 = b; req_sub[1] = sub; req_rm1 = rm; req_tag1 = tag; end
    endtask

    task automatic wait_result(input string name);
        for (int k = 0; k < 12 && !res_valid; k++) step();
        chk(name, res_valid, 1);
    endtask

    task automatic drain(input string name);
        req_valid = 2'b00;
        res_ready = 1'b1;
        for (int k = 0; k < 30 && busy; k++) step();
        chk(name, busy, 0);
    endtask

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 7))
                   0: v = 32'h00000000;
                   1: v = 32'h80000000;
                   2: v = 32'h7F800000;
                   3: v = 32'hFF800000;
                   4: v = 32'h7FC00001;
                   5: v = 32'h7F7FFFFF;
                   6: v = 32'h00000001;
                   default: v = other ^ 32'h80000000;
               endcase
            1, 2, 3: v[30:23] = other[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
            4: v[30:23] = 8'($urandom_range(0, 2));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int n_acc, d0;
        logic [31:0] ra;
        logic [1:0] exp_grant;

        chk("model_1p2", fp_ref(32'h3F800000, 32'h40000000, 1'b0, 2'd0), 32'h40400000);
        chk("model_3m1", fp_ref(32'h40400000, 32'h3F800000, 1'b1, 2'd0), 32'h40000000);
        chk("model_tie_rne", fp_ref(32'h3F800000, 32'h33800000, 1'b0, 2'd0), 32'h3F800000);
        chk("model_tie_rup", fp_ref(32'h3F800000, 32'h33800000, 1'b0, 2'd2), 32'h3F800001);
        chk("model_cancel_rdn", fp_ref(32'h3F800000, 32'h3F800000, 1'b1, 2'd3), 32'h80000000);
        chk("model_ovf_rz", fp_ref(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'd1), 32'h7F7FFFFF);

        repeat (2) step();
        chk("reset_res_data", res_data, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_res_tag", res_tag, 0);
        chk("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;
        step();

        // Single op from requester 0: visible after the third edge counting acceptance
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0, 2'd0, 4'd5);
        req_valid = 2'b01;
        #1 chk("single_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        chk("single_edge1", res_valid, 0);
        step();
        chk("single_edge2", res_valid, 0);
        step();
        chk("single_edge3_valid", res_valid, 1);
        chk("single_data", res_data, 32'h40400000);
        chk("single_id", res_id, 0);
        chk("single_tag", res_tag, 5);
        drain("single_drain");

        // Subtract from requester 1
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1, 2'd0, 4'd9);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        wait_result("sub_seen");
        chk("sub_data", res_data, 32'h40000000);
        chk("sub_id", res_id, 1);
        drain("sub_drain");

        // Both requesters every cycle: grants alternate starting with 0
        for (int c = 0; c < 6; c++) begin
            set_req(0, $urandom, $urandom, 1'($urandom), 2'($urandom), 4'(2 * c));
            set_req(1, $urandom, $urandom, 1'($urandom), 2'($urandom), 4'(2 * c + 1));
            req_valid = 2'b11;
            exp_grant = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1 chk("alt_grant", req_ready, exp_grant);
            step();
        end
        drain("alt_drain");

        // Back-pressure: result port refuses, so exactly three ops fit before the stall
        res_ready = 1'b0;
        d0 = delivered;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 32'h3F800000 + 32'(c), 32'h40800000, 1'b0, 2'd0, 4'(8 + n_acc));
            req_valid = 2'b01;
            #1 if (req_ready[0]) n_acc++;
            step();
        end
        chk("bp_accepted", n_acc, 3);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_busy", busy, 1);
        res_ready = 1'b1;
        for (int c = 0; c < 10 && n_acc < 4; c++) begin
            set_req(0, 32'h3F800000 + 32'(n_acc), 32'h40800000, 1'b0, 2'd0, 4'(8 + n_acc));
            #1 if (req_ready[0]) n_acc++;
            step();
        end
        chk("bp_accepted_all", n_acc, 4);
        drain("bp_drain");
        chk("bp_delivered", delivered - d0, 4);

        // Inf + -Inf gives a NaN carrying its tag
        set_req(0, 32'h7F800000, 32'hFF800000, 1'b0, 2'd0, 4'd3);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        wait_result("inf_seen");
        chk("inf_exp", res_data[30:23], 8'hFF);
        chk("inf_frac_nz", res_data[22:0] != 0, 1);
        chk("inf_tag", res_tag, 3);
        drain("inf_drain");

        // Reset with both adder stages occupied
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0, 2'd0, 4'd1);
        req_valid = 2'b01;
        step();
        set_req(0, 32'h40000000, 32'h3F800000, 1'b0, 2'd0, 4'd2);
        step();
        req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("midrst_no_stale", res_valid, 0);
        end
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0, 2'd0, 4'd4);
        set_req(1, 32'h3F800000, 32'h40000000, 1'b0, 2'd0, 4'd6);
        req_valid = 2'b11;
        #1 chk("midrst_tie_grant", req_ready, 2'b01);
        step();
        drain("midrst_drain");

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 600; c++) begin
            ra = $urandom;
            set_req(0, ra, rand_fp(ra), 1'($urandom), 2'($urandom), 4'($urandom));
            ra = rand_fp(32'($urandom));
            set_req(1, ra, rand_fp(ra), 1'($urandom), 2'($urandom), 4'($urandom));
            req_valid = 2'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand_drain");
        chk("rand_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
